// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter: controller state encoding and default operand width.
package div_pkg;
  localparam int BITSIZE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr, wrapping.
// Zero latency, no state; the caller owns the pointer register.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] winner,
  output logic [IDXW-1:0] win_idx
);

  always_comb begin
    int cand;
    logic [IDXW-1:0] c;
    winner  = '0;
    win_idx = '0;
    cand    = 0;
    c       = '0;
    // Scan farthest-first so the nearest requester after ptr overwrites earlier hits.
    for (int i = NREQ; i >= 1; i--) begin
      cand = (int'(ptr) + i) % NREQ;
      c    = IDXW'(cand);
      if (req[c]) begin
        winner    = '0;
        winner[c] = 1'b1;
        win_idx   = c;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one divider among NREQ requesters round-robin; grant one cycle after a request, done one cycle after divider idle.
// Requests are level-sensitive and simply wait while busy; DIV_ARB_ZERO_BYPASS_EN completes zero-divisor jobs without the divider.
module div_arbiter
  import div_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEF,
  parameter int NREQ    = 4,
  parameter int IDXW    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*BITSIZE-1:0]   dividend_in,
  input  logic [NREQ*BITSIZE-1:0]   divisor_in,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic [BITSIZE-1:0]        quotient,
  output logic [BITSIZE-1:0]        remainder,
  output logic                      div_by_zero,
  output logic                      busy,
  output logic                      div_strt,
  output logic [BITSIZE-1:0]        div_dividend,
  output logic [BITSIZE-1:0]        div_divisor,
  input  logic [BITSIZE-1:0]        div_quotient,
  input  logic [BITSIZE-1:0]        div_remainder,
  input  logic                      div_not_valid,
  input  logic                      div_idle
);

  state_t              state_q, state_d;
  logic [IDXW-1:0]     ptr_q, ptr_d, sel_q, sel_d;
  logic [NREQ-1:0]     grant_q, grant_d, done_q, done_d;
  logic [BITSIZE-1:0]  quot_q, quot_d, rem_q, rem_d, opa_q, opa_d, opb_q, opb_d;
  logic                dbz_q, dbz_d;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  logic                byp_q, byp_d;
`endif

  logic [NREQ-1:0]     rr_win;
  logic [IDXW-1:0]     rr_idx;
  logic [BITSIZE-1:0]  win_a, win_b;

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (rr_win),
    .win_idx (rr_idx)
  );

  assign win_a = dividend_in[int'(rr_idx)*BITSIZE +: BITSIZE];
  assign win_b = divisor_in[int'(rr_idx)*BITSIZE +: BITSIZE];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = '0;
    done_d  = '0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    byp_d   = byp_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req && div_idle) begin
          grant_d = rr_win;
          sel_d   = rr_idx;
          ptr_d   = rr_idx;
          opa_d   = win_a;
          opb_d   = win_b;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          // Zero divisor skips ISSUE so the divider never starts.
          byp_d   = (win_b == '0);
          state_d = (win_b == '0) ? WAIT : ISSUE;
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
`ifdef DIV_ARB_ZERO_BYPASS_EN
        if (byp_q) begin
          done_d[sel_q] = 1'b1;
          quot_d        = '1;
          rem_d         = opa_q;
          dbz_d         = 1'b1;
          byp_d         = 1'b0;
          state_d       = IDLE;
        end else
`endif
        if (div_idle) begin
          done_d[sel_q] = 1'b1;
          quot_d        = div_quotient;
          rem_d         = div_remainder;
          dbz_d         = div_not_valid;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDXW'(NREQ-1);
      sel_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      byp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      byp_q   <= byp_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign quotient     = quot_q;
  assign remainder    = rem_q;
  assign div_by_zero  = dbz_q;
  assign busy         = (state_q != IDLE);
  assign div_strt     = (state_q == ISSUE);
  assign div_dividend = opa_q;
  assign div_divisor  = opb_q;

endmodule
